// File: rtl/hy_cnt_bank_if.sv
// Configuration/status bus of the counter bank: config strobe, run enables,
// interrupt clears, live counts and sticky interrupt flags.
interface hy_cnt_bank_if #(
   parameter int unsigned C_WIDTH   = 32,
   parameter int unsigned N_CH      = 4,
   parameter int unsigned PRE_WIDTH = 16
);
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [PRE_WIDTH-1:0]      prescale;
   logic                      cfg_we;
   logic [CH_W-1:0]           cfg_ch;
   logic [1:0]                cfg_mode;
   logic [C_WIDTH-1:0]        cfg_val;
   logic [N_CH-1:0]           ch_en;
   logic [N_CH-1:0]           int_clr;
   logic [N_CH*C_WIDTH-1:0]   cnt_out;
   // 'int' is a reserved word, so the interrupt vector is carried as int_flag
   logic [N_CH-1:0]           int_flag;

   modport master (
      output prescale, cfg_we, cfg_ch, cfg_mode, cfg_val, ch_en, int_clr,
      input  cnt_out, int_flag
   );

   modport slave (
      input  prescale, cfg_we, cfg_ch, cfg_mode, cfg_val, ch_en, int_clr,
      output cnt_out, int_flag
   );
endinterface

// File: rtl/hy_cnt_bank.sv
// Bank of N_CH independent programmable counters (oneshot / periodic down,
// free-running up) driven by one shared prescaler tick.
module hy_cnt_bank #(
   parameter int unsigned C_WIDTH   = 32,
   parameter int unsigned N_CH      = 4,
   parameter int unsigned PRE_WIDTH = 16
) (
   input logic          clk,
   input logic          rst_n,
   hy_cnt_bank_if.slave bus
);
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [1:0] MODE_OFF      = 2'b00;
   localparam logic [1:0] MODE_ONESHOT  = 2'b01;
   localparam logic [1:0] MODE_PERIODIC = 2'b10;
   localparam logic [1:0] MODE_FREERUN  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   logic [PRE_WIDTH-1:0]           pre_cnt;
   logic                           tick;
   logic [N_CH-1:0][C_WIDTH-1:0]   cnt_all;
   logic [N_CH-1:0]                int_all;

   // Compare against the live prescale; an overshoot runs to max and wraps
   assign tick = (pre_cnt == bus.prescale);

   // Shared prescaler
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_WIDTH'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

      state_t             state;
      logic [1:0]         mode;
      logic [C_WIDTH-1:0] cnt;
      logic [C_WIDTH-1:0] reload;
      logic               irq;
      logic               wr;
      logic               at_end;
      logic               fire;

      assign wr     = bus.cfg_we && (bus.cfg_ch == CH_IDX);
      assign at_end = (mode == MODE_FREERUN) ? (cnt == '1) : (cnt == '0);
      // A config write to this channel suppresses its tick entirely
      assign fire   = !wr && (state == ST_RUN) && bus.ch_en[i] && tick &&
                      (mode != MODE_OFF) && at_end;

      // Per-channel state, count, reload and sticky interrupt
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= ST_IDLE;
            mode   <= MODE_OFF;
            cnt    <= '0;
            reload <= '0;
            irq    <= 1'b0;
         end else begin
            if (wr) begin
               reload <= bus.cfg_val;
               mode   <= bus.cfg_mode;
               cnt    <= (bus.cfg_mode == MODE_FREERUN) ? '0 : bus.cfg_val;
               state  <= ST_IDLE;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (bus.ch_en[i] && (mode != MODE_OFF)) begin
                        state <= ST_RUN;
                     end
                  end
                  ST_RUN: begin
                     if (!bus.ch_en[i]) begin
                        state <= ST_IDLE;
                     end else if (tick) begin
                        case (mode)
                           MODE_ONESHOT: begin
                              if (cnt != '0) cnt <= cnt - C_WIDTH'(1);
                              else           state <= ST_DONE;
                           end
                           MODE_PERIODIC: begin
                              if (cnt != '0) cnt <= cnt - C_WIDTH'(1);
                              else           cnt <= reload;
                           end
                           MODE_FREERUN: begin
                              cnt <= cnt + C_WIDTH'(1);
                           end
                           default: begin
                              state <= ST_IDLE;
                           end
                        endcase
                     end
                  end
                  ST_DONE: begin
                     state <= ST_DONE;
                  end
                  default: begin
                     state <= ST_IDLE;
                  end
               endcase
            end
            // Set beats a coincident clear
            irq <= fire | (irq & ~bus.int_clr[i]);
         end
      end

      assign cnt_all[i] = cnt;
      assign int_all[i] = irq;
   end

   assign bus.cnt_out  = cnt_all;
   assign bus.int_flag = int_all;

endmodule

// File: tb/tb_hy_cnt_bank.sv
// Bench for hy_cnt_bank: a 32-bit and an 8-bit instance share one stimulus
// stream and are both tracked by a rule-level reference model every cycle.
module tb_hy_cnt_bank;
   localparam int unsigned NCH = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   hy_cnt_bank_if #(.C_WIDTH(32), .N_CH(NCH), .PRE_WIDTH(16)) b32 ();
   hy_cnt_bank_if #(.C_WIDTH(8),  .N_CH(NCH), .PRE_WIDTH(16)) b8 ();

   assign b8.prescale = b32.prescale;
   assign b8.cfg_we   = b32.cfg_we;
   assign b8.cfg_ch   = b32.cfg_ch;
   assign b8.cfg_mode = b32.cfg_mode;
   assign b8.cfg_val  = b32.cfg_val[7:0];
   assign b8.ch_en    = b32.ch_en;
   assign b8.int_clr  = b32.int_clr;

   hy_cnt_bank #(.C_WIDTH(32), .N_CH(NCH), .PRE_WIDTH(16)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32.slave));
   hy_cnt_bank #(.C_WIDTH(8), .N_CH(NCH), .PRE_WIDTH(16)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .bus(b8.slave));

   // ---------------- reference model ----------------
   logic [31:0] m_cnt  [2][NCH];
   logic [31:0] m_rel  [2][NCH];
   logic [1:0]  m_mode [2][NCH];
   bit          m_run  [2][NCH];
   bit          m_done [2][NCH];
   bit          m_int  [2][NCH];
   logic [15:0] m_pre;

   function automatic logic [31:0] wmask(int d);
      return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            m_cnt[d][c] = 32'h0; m_rel[d][c] = 32'h0; m_mode[d][c] = 2'b00;
            m_run[d][c] = 1'b0;  m_done[d][c] = 1'b0; m_int[d][c] = 1'b0;
         end
      end
      m_pre = 16'h0;
   endtask

   task automatic model_step();
      bit          tick;
      bit          wr;
      bit          fire;
      logic [31:0] mk;
      logic [31:0] v;
      tick = (m_pre == b32.prescale);
      for (int d = 0; d < 2; d++) begin
         mk = wmask(d);
         for (int c = 0; c < NCH; c++) begin
            wr   = b32.cfg_we && (int'(b32.cfg_ch) == c);
            fire = 1'b0;
            if (wr) begin
               v = b32.cfg_val & mk;
               m_rel[d][c]  = v;
               m_mode[d][c] = b32.cfg_mode;
               m_cnt[d][c]  = (b32.cfg_mode == 2'b11) ? 32'h0 : v;
               m_run[d][c]  = 1'b0;
               m_done[d][c] = 1'b0;
            end else if (m_run[d][c]) begin
               if (!b32.ch_en[c]) begin
                  m_run[d][c] = 1'b0;
               end else if (tick) begin
                  case (m_mode[d][c])
                     2'b01: if (m_cnt[d][c] == 0) begin
                               fire = 1'b1; m_run[d][c] = 1'b0; m_done[d][c] = 1'b1;
                            end else m_cnt[d][c] = m_cnt[d][c] - 1;
                     2'b10: if (m_cnt[d][c] == 0) begin
                               fire = 1'b1; m_cnt[d][c] = m_rel[d][c];
                            end else m_cnt[d][c] = m_cnt[d][c] - 1;
                     2'b11: begin
                               fire = (m_cnt[d][c] == mk);
                               m_cnt[d][c] = (m_cnt[d][c] + 1) & mk;
                            end
                     default: ;
                  endcase
               end
            end else if (!m_done[d][c] && b32.ch_en[c] && m_mode[d][c] != 2'b00) begin
               m_run[d][c] = 1'b1;
            end
            m_int[d][c] = fire || (m_int[d][c] && !b32.int_clr[c]);
         end
      end
      m_pre = tick ? 16'h0 : m_pre + 16'h1;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dut_cnt(int d, int c);
      if (d == 0) return b32.cnt_out[c*32 +: 32];
      return {24'h0, b8.cnt_out[c*8 +: 8]};
   endfunction

   function automatic logic [3:0] dut_int(int d);
      return (d == 0) ? b32.int_flag : b8.int_flag;
   endfunction

   task automatic compare_all();
      logic [3:0] ei;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < NCH; c++) begin
            chk($sformatf("model_cnt d%0d ch%0d", d, c), dut_cnt(d, c), m_cnt[d][c]);
            ei[c] = m_int[d][c];
         end
         chk($sformatf("model_int d%0d", d), {28'h0, dut_int(d)}, {28'h0, ei});
      end
   endtask

   // One clock: advance model from the pre-edge inputs, then compare
   task automatic cyc();
      if (!rst_n) model_reset();
      else        model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_cfg(bit we, int ch, logic [1:0] mode, logic [31:0] val);
      b32.cfg_we   = we;
      b32.cfg_ch   = 2'(ch);
      b32.cfg_mode = mode;
      b32.cfg_val  = val;
   endtask

   task automatic do_reset(logic [15:0] ps);
      rst_n = 1'b0;
      set_cfg(1'b0, 0, 2'b00, 32'h0);
      b32.ch_en    = '0;
      b32.int_clr  = '0;
      b32.prescale = ps;
      model_reset();
      repeat (2) cyc();
      rst_n = 1'b1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        we;
      logic [1:0]  ch;
      logic [1:0]  mode;
      logic [31:0] val;
      logic [3:0]  en;
      logic [3:0]  clr;
      logic [31:0] e_cnt1;
      logic [3:0]  e_int;
   } vec_t;

   vec_t tbl[21];

   initial begin
      int          n;
      logic [3:0]  en_tmp;
      bit          hit;

      // ch1 PERIODIC reload 2, tick every clk: enable gating, clear/set race,
      // write coincident with tick, mode OFF never runs
      tbl[0]  = '{1'b1, 2'd1, 2'b10, 32'h2,  4'b0000, 4'b0000, 32'h2,  4'b0000};
      tbl[1]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h2,  4'b0000};
      tbl[2]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h1,  4'b0000};
      tbl[3]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h0,  4'b0000};
      tbl[4]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h2,  4'b0010};
      tbl[5]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h1,  4'b0010};
      tbl[6]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0010, 32'h0,  4'b0000};
      tbl[7]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h2,  4'b0010};
      tbl[8]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0010, 32'h1,  4'b0000};
      tbl[9]  = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0000, 4'b0000, 32'h1,  4'b0000};
      tbl[10] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0000, 4'b0000, 32'h1,  4'b0000};
      tbl[11] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h1,  4'b0000};
      tbl[12] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h0,  4'b0000};
      tbl[13] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0010, 32'h2,  4'b0010};
      tbl[14] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0010, 32'h1,  4'b0000};
      tbl[15] = '{1'b1, 2'd1, 2'b10, 32'h10, 4'b0010, 4'b0000, 32'h10, 4'b0000};
      tbl[16] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h10, 4'b0000};
      tbl[17] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h0F, 4'b0000};
      tbl[18] = '{1'b1, 2'd1, 2'b00, 32'h5,  4'b0010, 4'b0000, 32'h5,  4'b0000};
      tbl[19] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h5,  4'b0000};
      tbl[20] = '{1'b0, 2'd0, 2'b00, 32'h0,  4'b0010, 4'b0000, 32'h5,  4'b0000};

      // Reset state
      do_reset(16'd0);
      for (int c = 0; c < NCH; c++) chk($sformatf("rst_cnt ch%0d", c), dut_cnt(0, c), 32'h0);
      chk("rst_int", {28'h0, b32.int_flag}, 32'h0);

      // Table
      for (int k = 0; k < 21; k++) begin
         set_cfg(tbl[k].we, int'(tbl[k].ch), tbl[k].mode, tbl[k].val);
         b32.ch_en   = tbl[k].en;
         b32.int_clr = tbl[k].clr;
         cyc();
         chk($sformatf("tbl%0d cnt1", k), dut_cnt(0, 1), tbl[k].e_cnt1);
         chk($sformatf("tbl%0d int", k), {28'h0, b32.int_flag}, {28'h0, tbl[k].e_int});
      end

      // Oneshot 0xA5: fires on tick 0xA6 after entering RUN, count stays 0
      do_reset(16'd0);
      set_cfg(1'b1, 0, 2'b01, 32'hA5); cyc();
      set_cfg(1'b0, 0, 2'b00, 32'h0); b32.ch_en = 4'b0001; cyc();
      repeat (32'hA5) cyc();
      chk("t1_int_early", {31'h0, b32.int_flag[0]}, 32'h0);
      chk("t1_cnt_zero", dut_cnt(0, 0), 32'h0);
      cyc();
      chk("t1_int_fire", {31'h0, b32.int_flag[0]}, 32'h1);
      b32.int_clr = 4'b0001; cyc(); b32.int_clr = 4'b0000;
      chk("t1_int_clr", {31'h0, b32.int_flag[0]}, 32'h0);
      repeat (10) cyc();
      chk("t1_no_refire", {31'h0, b32.int_flag[0]}, 32'h0);
      chk("t1_cnt_hold", dut_cnt(0, 0), 32'h0);

      // Periodic 3 with prescale 4: one interrupt every 20 clocks
      do_reset(16'd4);
      set_cfg(1'b1, 1, 2'b10, 32'h3); cyc();
      set_cfg(1'b0, 0, 2'b00, 32'h0); b32.ch_en = 4'b0010;
      n = 0;
      while (!b32.int_flag[1] && n < 100) begin cyc(); n++; end
      chk("t2_first_fire", {31'h0, b32.int_flag[1]}, 32'h1);
      chk("t2_reload", dut_cnt(0, 1), 32'h3);
      b32.int_clr = 4'b0010; cyc(); b32.int_clr = 4'b0000;
      n = 1;
      while (!b32.int_flag[1] && n < 100) begin cyc(); n++; end
      chk("t2_period", 32'(n), 32'd20);

      // Freerun on the 8-bit instance wraps after 256 ticks
      do_reset(16'd0);
      set_cfg(1'b1, 2, 2'b11, 32'h0); cyc();
      set_cfg(1'b0, 0, 2'b00, 32'h0); b32.ch_en = 4'b0100; cyc();
      repeat (255) cyc();
      chk("t3_cnt_ff", dut_cnt(1, 2), 32'hFF);
      chk("t3_int_pre", {31'h0, b8.int_flag[2]}, 32'h0);
      cyc();
      chk("t3_cnt_wrap", dut_cnt(1, 2), 32'h0);
      chk("t3_int_wrap", {31'h0, b8.int_flag[2]}, 32'h1);

      // Asynchronous reset mid-count, then channels stay idle until reconfigured
      do_reset(16'd0);
      set_cfg(1'b1, 0, 2'b01, 32'h50); cyc();
      set_cfg(1'b1, 1, 2'b10, 32'h0); cyc();
      set_cfg(1'b0, 0, 2'b00, 32'h0); b32.ch_en = 4'b0011;
      n = 0;
      hit = 1'b0;
      while (!hit && n < 60) begin
         cyc(); n++;
         hit = (dut_cnt(0, 0) == 32'h40);
      end
      chk("t6_reach_40", {31'h0, hit}, 32'h1);
      chk("t6_int_before", {31'h0, b32.int_flag[1]}, 32'h1);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("t6_async_cnt32 ch%0d", c), dut_cnt(0, c), 32'h0);
         chk($sformatf("t6_async_cnt8 ch%0d", c), dut_cnt(1, c), 32'h0);
      end
      chk("t6_async_int", {28'h0, b32.int_flag}, 32'h0);
      repeat (3) cyc();
      rst_n = 1'b1;
      b32.ch_en = 4'b1111;
      repeat (5) cyc();
      chk("t6_idle_cnt", dut_cnt(0, 0), 32'h0);
      chk("t6_idle_int", {28'h0, b32.int_flag}, 32'h0);
      set_cfg(1'b1, 0, 2'b01, 32'h3); cyc();
      set_cfg(1'b0, 0, 2'b00, 32'h0);
      repeat (3) cyc();
      chk("t6_reconf", dut_cnt(0, 0), 32'h1);

      // Randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 29) == 0) begin
            en_tmp = b32.ch_en;
            en_tmp[$urandom_range(0, 3)] ^= 1'b1;
            b32.ch_en = en_tmp;
         end
         if ($urandom_range(0, 14) == 0) begin
            set_cfg(1'b1, int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 12)));
         end else begin
            b32.cfg_we = 1'b0;
         end
         b32.int_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
         if (m_pre == 16'h0 && $urandom_range(0, 49) == 0)
            b32.prescale = 16'($urandom_range(0, 3));
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
